// File: rtl/reversi_pkg.sv
// Shared definitions for the reversi datapath: cell/player/winner codes,
// board geometry and the turn controller state encoding.
package reversi_pkg;

    localparam logic [2:0] CELL_EMPTY = 3'b000;
    localparam logic [2:0] CELL_WHITE = 3'b110;
    localparam logic [2:0] CELL_BLACK = 3'b111;

    localparam logic PLAYER_BLACK = 1'b0;
    localparam logic PLAYER_WHITE = 1'b1;

    localparam logic [1:0] WINNER_NONE  = 2'b00;
    localparam logic [1:0] WINNER_BLACK = 2'b01;
    localparam logic [1:0] WINNER_WHITE = 2'b10;
    localparam logic [1:0] WINNER_DRAW  = 2'b11;

    localparam int unsigned BOARD_CELLS = 64;
    localparam int unsigned BOARD_W     = 192;
    localparam int unsigned POS_W       = 6;
    localparam int unsigned SCORE_W     = 7;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_INIT,
        ST_WAIT_MOVE,
        ST_CHECK_ISSUE,
        ST_CHECK_WAIT,
        ST_COMMIT,
        ST_COUNT_ISSUE,
        ST_COUNT_WAIT,
        ST_PROBE_OPP_ISSUE,
        ST_PROBE_OPP_WAIT,
        ST_PROBE_SELF_ISSUE,
        ST_PROBE_SELF_WAIT,
        ST_END,
        ST_FAULT
    } ctrl_state_e;

    function automatic logic [1:0] pick_winner(input logic [SCORE_W-1:0] black,
                                               input logic [SCORE_W-1:0] white);
        if (black > white)      return WINNER_BLACK;
        else if (white > black) return WINNER_WHITE;
        else                    return WINNER_DRAW;
    endfunction

endpackage

// File: rtl/reversi_timeout_ctr.sv
// Watchdog counter: load clears it, en advances it, expired latches once
// TIMEOUT enabled cycles have elapsed since the last load.
module reversi_timeout_ctr #(
    parameter int unsigned TIMEOUT = 512,
    parameter int unsigned TO_W    = 10
) (
    input  logic clk,
    input  logic resetn,
    input  logic load,
    input  logic en,
    output logic expired
);

    logic [TO_W-1:0] count;
    logic [TO_W-1:0] count_inc;

    assign count_inc = count + TO_W'(1);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            count   <= '0;
            expired <= 1'b0;
        end else if (load) begin
            count   <= '0;
            expired <= 1'b0;
        end else if (en && !expired) begin
            count   <= count_inc;
            expired <= (count_inc == TO_W'(TIMEOUT));
        end
    end

endmodule

// File: rtl/reversi_turn_ctrl.sv
// Game-flow controller: accepts moves, drives the move checker, board commit
// and score counter, then decides the next player, passes and game end.
module reversi_turn_ctrl
    import reversi_pkg::*;
#(
    parameter int unsigned TIMEOUT = 512,
    parameter int unsigned TO_W    = 10
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       new_game,
    input  logic       move_valid,
    input  logic [5:0] move_pos,
    output logic       move_ready,
    output logic       chk_start,
    output logic       chk_mode,
    output logic       chk_player,
    output logic [5:0] chk_pos,
    input  logic       chk_done,
    input  logic       chk_legal,
    output logic       commit_en,
    output logic       score_init,
    output logic       score_start,
    input  logic       score_done,
    input  logic [6:0] score_black,
    input  logic [6:0] score_white,
    output logic       cur_player,
    output logic       pass_evt,
    output logic       illegal_move,
    output logic       game_over,
    output logic [1:0] winner,
    output logic       fault
);

    ctrl_state_e      state;
    logic [6:0]       black_q;
    logic [6:0]       white_q;
    logic [7:0]       score_sum;
    logic             board_final;
    logic             to_load;
    logic             to_en;
    logic             to_expired;

    // Full board or a wiped-out colour ends the game without probing.
    assign score_sum   = 8'(score_black) + 8'(score_white);
    assign board_final = (score_sum == 8'(BOARD_CELLS)) ||
                         (score_black == 7'd0) || (score_white == 7'd0);

    assign to_load = chk_start || score_start;
    assign to_en   = (state == ST_CHECK_WAIT)     || (state == ST_COUNT_WAIT) ||
                     (state == ST_PROBE_OPP_WAIT) || (state == ST_PROBE_SELF_WAIT);

    reversi_timeout_ctr #(
        .TIMEOUT (TIMEOUT),
        .TO_W    (TO_W)
    ) u_timeout (
        .clk     (clk),
        .resetn  (resetn),
        .load    (to_load),
        .en      (to_en),
        .expired (to_expired)
    );

    // Pulse outputs are raised on the edge that enters their state.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state        <= ST_IDLE;
            move_ready   <= 1'b0;
            chk_start    <= 1'b0;
            chk_mode     <= 1'b0;
            chk_player   <= PLAYER_BLACK;
            chk_pos      <= '0;
            commit_en    <= 1'b0;
            score_init   <= 1'b0;
            score_start  <= 1'b0;
            cur_player   <= PLAYER_BLACK;
            pass_evt     <= 1'b0;
            illegal_move <= 1'b0;
            game_over    <= 1'b0;
            winner       <= WINNER_NONE;
            fault        <= 1'b0;
            black_q      <= '0;
            white_q      <= '0;
        end else begin
            chk_start    <= 1'b0;
            commit_en    <= 1'b0;
            score_init   <= 1'b0;
            score_start  <= 1'b0;
            pass_evt     <= 1'b0;
            illegal_move <= 1'b0;

            if (new_game) begin
                state      <= ST_INIT;
                score_init <= 1'b1;
                move_ready <= 1'b0;
                cur_player <= PLAYER_BLACK;
                game_over  <= 1'b0;
                winner     <= WINNER_NONE;
                fault      <= 1'b0;
            end else begin
                case (state)
                    ST_INIT: begin
                        state      <= ST_WAIT_MOVE;
                        move_ready <= 1'b1;
                    end
                    ST_WAIT_MOVE: begin
                        if (move_valid && move_ready) begin
                            state      <= ST_CHECK_ISSUE;
                            move_ready <= 1'b0;
                            chk_pos    <= move_pos;
                            chk_mode   <= 1'b0;
                            chk_player <= cur_player;
                            chk_start  <= 1'b1;
                        end
                    end
                    ST_CHECK_ISSUE: state <= ST_CHECK_WAIT;
                    ST_CHECK_WAIT: begin
                        if (chk_done) begin
                            if (chk_legal) begin
                                state     <= ST_COMMIT;
                                commit_en <= 1'b1;
                            end else begin
                                state        <= ST_WAIT_MOVE;
                                move_ready   <= 1'b1;
                                illegal_move <= 1'b1;
                            end
                        end else if (to_expired) begin
                            state <= ST_FAULT;
                            fault <= 1'b1;
                        end
                    end
                    ST_COMMIT: begin
                        state       <= ST_COUNT_ISSUE;
                        score_start <= 1'b1;
                    end
                    ST_COUNT_ISSUE: state <= ST_COUNT_WAIT;
                    ST_COUNT_WAIT: begin
                        if (score_done) begin
                            black_q <= score_black;
                            white_q <= score_white;
                            if (board_final) begin
                                state     <= ST_END;
                                game_over <= 1'b1;
                                winner    <= pick_winner(score_black, score_white);
                            end else begin
                                state      <= ST_PROBE_OPP_ISSUE;
                                chk_start  <= 1'b1;
                                chk_mode   <= 1'b1;
                                chk_player <= ~cur_player;
                            end
                        end else if (to_expired) begin
                            state <= ST_FAULT;
                            fault <= 1'b1;
                        end
                    end
                    ST_PROBE_OPP_ISSUE: state <= ST_PROBE_OPP_WAIT;
                    ST_PROBE_OPP_WAIT: begin
                        if (chk_done) begin
                            if (chk_legal) begin
                                state      <= ST_WAIT_MOVE;
                                move_ready <= 1'b1;
                                cur_player <= ~cur_player;
                            end else begin
                                state      <= ST_PROBE_SELF_ISSUE;
                                chk_start  <= 1'b1;
                                chk_mode   <= 1'b1;
                                chk_player <= cur_player;
                            end
                        end else if (to_expired) begin
                            state <= ST_FAULT;
                            fault <= 1'b1;
                        end
                    end
                    ST_PROBE_SELF_ISSUE: state <= ST_PROBE_SELF_WAIT;
                    ST_PROBE_SELF_WAIT: begin
                        if (chk_done) begin
                            if (chk_legal) begin
                                state      <= ST_WAIT_MOVE;
                                move_ready <= 1'b1;
                                pass_evt   <= 1'b1;
                            end else begin
                                state     <= ST_END;
                                game_over <= 1'b1;
                                winner    <= pick_winner(black_q, white_q);
                            end
                        end else if (to_expired) begin
                            state <= ST_FAULT;
                            fault <= 1'b1;
                        end
                    end
                    ST_IDLE, ST_END, ST_FAULT: state <= state;
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_reversi_turn_ctrl.sv
// Self-checking bench for reversi_turn_ctrl: a table of moves with emulated
// checker/score responses, scoreboarded per move, plus timeout/reset sequences.
module tb_reversi_turn_ctrl;
    import reversi_pkg::*;

    logic       clk = 1'b0;
    logic       resetn, new_game, move_valid;
    logic [5:0] move_pos;
    logic       move_ready, chk_start, chk_mode, chk_player;
    logic [5:0] chk_pos;
    logic       chk_done, chk_legal, commit_en, score_init, score_start, score_done;
    logic [6:0] score_black, score_white;
    logic       cur_player, pass_evt, illegal_move, game_over, fault;
    logic [1:0] winner;

    always #5 clk = ~clk;

    reversi_turn_ctrl #(.TIMEOUT(512), .TO_W(10)) dut (
        .clk(clk), .resetn(resetn), .new_game(new_game), .move_valid(move_valid),
        .move_pos(move_pos), .move_ready(move_ready), .chk_start(chk_start),
        .chk_mode(chk_mode), .chk_player(chk_player), .chk_pos(chk_pos),
        .chk_done(chk_done), .chk_legal(chk_legal), .commit_en(commit_en),
        .score_init(score_init), .score_start(score_start), .score_done(score_done),
        .score_black(score_black), .score_white(score_white), .cur_player(cur_player),
        .pass_evt(pass_evt), .illegal_move(illegal_move), .game_over(game_over),
        .winner(winner), .fault(fault)
    );

    typedef struct {
        logic       ng;
        logic [5:0] pos;
        logic       ml;
        logic [6:0] sb;
        logic [6:0] sw;
        logic       opp;
        logic       slf;
        int         com;
        int         prb;
        int         ill;
        int         pas;
        logic       cur;
        logic       go;
        logic [1:0] win;
    } vec_t;

    typedef struct {
        int         com;
        int         ss;
        int         prb;
        int         ill;
        int         pas;
        logic       cur;
        logic       go;
        logic [1:0] win;
        logic       rdy;
    } exp_t;

    exp_t sb_q[$];
    vec_t vecs[11];

    int   n_checks = 0;
    int   n_errors = 0;
    int   n_init, n_chk0, n_chk1, n_commit, n_sstart, n_pass, n_ill, n_badprobe, probe_idx;
    logic exp_mover = 1'b0;
    logic [5:0] exp_pos = '0;
    logic cur_mover = 1'b0;

    // Emulated checker/score counter settings
    logic       rsp_move_legal = 1'b0, rsp_opp_legal = 1'b0, rsp_self_legal = 1'b0;
    logic [6:0] rsp_sb = '0, rsp_sw = '0;
    logic       hold_chk = 1'b0, hold_score = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task clr();
        n_init = 0; n_chk0 = 0; n_chk1 = 0; n_commit = 0; n_sstart = 0;
        n_pass = 0; n_ill = 0; n_badprobe = 0; probe_idx = 0;
    endtask

    task tick();
        @(negedge clk);
        if (score_init)   n_init++;
        if (commit_en)    n_commit++;
        if (score_start)  n_sstart++;
        if (pass_evt)     n_pass++;
        if (illegal_move) n_ill++;
        if (chk_start) begin
            if (!chk_mode) begin
                n_chk0++;
                if (chk_player !== exp_mover || chk_pos !== exp_pos) n_badprobe++;
            end else begin
                n_chk1++;
                if (chk_player !== ((probe_idx == 0) ? ~exp_mover : exp_mover)) n_badprobe++;
                probe_idx++;
            end
        end
    endtask

    // Checker and score counter models answer two cycles after each start.
    initial begin
        logic lg;
        chk_done = 1'b0; chk_legal = 1'b0; score_done = 1'b0;
        score_black = '0; score_white = '0;
        forever begin
            @(negedge clk);
            chk_done = 1'b0; chk_legal = 1'b0; score_done = 1'b0;
            if (chk_start && !hold_chk) begin
                lg = !chk_mode ? rsp_move_legal :
                     ((chk_player != exp_mover) ? rsp_opp_legal : rsp_self_legal);
                repeat (2) @(negedge clk);
                chk_done = 1'b1; chk_legal = lg;
            end else if (score_start && !hold_score) begin
                repeat (2) @(negedge clk);
                score_done = 1'b1; score_black = rsp_sb; score_white = rsp_sw;
            end
        end
    end

    task check_reset_outputs(input string tag);
        chk({tag, "_move_ready"}, int'(move_ready), 0);
        chk({tag, "_chk_start"}, int'(chk_start), 0);
        chk({tag, "_chk_mode"}, int'(chk_mode), 0);
        chk({tag, "_chk_player"}, int'(chk_player), 0);
        chk({tag, "_chk_pos"}, int'(chk_pos), 0);
        chk({tag, "_commit_en"}, int'(commit_en), 0);
        chk({tag, "_score_init"}, int'(score_init), 0);
        chk({tag, "_score_start"}, int'(score_start), 0);
        chk({tag, "_cur_player"}, int'(cur_player), 0);
        chk({tag, "_pass_evt"}, int'(pass_evt), 0);
        chk({tag, "_illegal"}, int'(illegal_move), 0);
        chk({tag, "_game_over"}, int'(game_over), 0);
        chk({tag, "_winner"}, int'(winner), 0);
        chk({tag, "_fault"}, int'(fault), 0);
    endtask

    task do_new_game();
        clr();
        new_game = 1'b1;
        tick();
        new_game = 1'b0;
        tick();
        chk("ng_score_init", n_init, 1);
        chk("ng_move_ready", int'(move_ready), 1);
        chk("ng_cur_player", int'(cur_player), 0);
        chk("ng_game_over", int'(game_over), 0);
        chk("ng_winner", int'(winner), 0);
        chk("ng_fault", int'(fault), 0);
        cur_mover = 1'b0;
    endtask

    task run_vec(input int idx);
        vec_t v;
        exp_t e;
        int   done;
        v = vecs[idx];
        if (v.ng) do_new_game();
        clr();
        exp_mover = cur_mover; exp_pos = v.pos;
        rsp_move_legal = v.ml; rsp_opp_legal = v.opp; rsp_self_legal = v.slf;
        rsp_sb = v.sb; rsp_sw = v.sw;
        e = '{v.com, v.com, v.prb, v.ill, v.pas, v.cur, v.go, v.win, !v.go};
        sb_q.push_back(e);
        move_valid = 1'b1; move_pos = v.pos;
        tick();
        move_valid = 1'b0;
        done = 0;
        for (int i = 0; i < 200 && done == 0; i++) begin
            tick();
            if (move_ready || game_over || fault) done = 1;
        end
        repeat (3) tick();
        chk($sformatf("v%0d_settle", idx), done, 1);
        e = sb_q.pop_front();
        chk($sformatf("v%0d_chk_issue", idx), n_chk0, 1);
        chk($sformatf("v%0d_bad_probe", idx), n_badprobe, 0);
        chk($sformatf("v%0d_commit", idx), n_commit, e.com);
        chk($sformatf("v%0d_score_start", idx), n_sstart, e.ss);
        chk($sformatf("v%0d_probes", idx), n_chk1, e.prb);
        chk($sformatf("v%0d_illegal", idx), n_ill, e.ill);
        chk($sformatf("v%0d_pass", idx), n_pass, e.pas);
        chk($sformatf("v%0d_cur_player", idx), int'(cur_player), int'(e.cur));
        chk($sformatf("v%0d_game_over", idx), int'(game_over), int'(e.go));
        chk($sformatf("v%0d_winner", idx), int'(winner), int'(e.win));
        chk($sformatf("v%0d_move_ready", idx), int'(move_ready), int'(e.rdy));
        cur_mover = e.cur;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int cycles;
        //            ng    pos     ml    sb     sw     opp   slf  com prb ill pas cur   go    win
        vecs[0]  = '{1'b1, 6'd19, 1'b1, 7'd4,  7'd1,  1'b1, 1'b0, 1, 1, 0, 0, 1'b1, 1'b0, 2'b00};
        vecs[1]  = '{1'b0, 6'd0,  1'b0, 7'd0,  7'd0,  1'b0, 1'b0, 0, 0, 1, 0, 1'b1, 1'b0, 2'b00};
        vecs[2]  = '{1'b0, 6'd20, 1'b1, 7'd5,  7'd3,  1'b0, 1'b1, 1, 2, 0, 1, 1'b1, 1'b0, 2'b00};
        vecs[3]  = '{1'b0, 6'd21, 1'b1, 7'd6,  7'd4,  1'b1, 1'b0, 1, 1, 0, 0, 1'b0, 1'b0, 2'b00};
        vecs[4]  = '{1'b0, 6'd44, 1'b1, 7'd40, 7'd24, 1'b0, 1'b0, 1, 0, 0, 0, 1'b0, 1'b1, 2'b01};
        vecs[5]  = '{1'b1, 6'd19, 1'b1, 7'd32, 7'd32, 1'b1, 1'b1, 1, 0, 0, 0, 1'b0, 1'b1, 2'b11};
        vecs[6]  = '{1'b1, 6'd19, 1'b1, 7'd30, 7'd20, 1'b0, 1'b0, 1, 2, 0, 0, 1'b0, 1'b1, 2'b01};
        vecs[7]  = '{1'b1, 6'd19, 1'b1, 7'd0,  7'd10, 1'b1, 1'b1, 1, 0, 0, 0, 1'b0, 1'b1, 2'b10};
        vecs[8]  = '{1'b1, 6'd63, 1'b1, 7'd33, 7'd30, 1'b1, 1'b0, 1, 1, 0, 0, 1'b1, 1'b0, 2'b00};
        vecs[9]  = '{1'b0, 6'd5,  1'b1, 7'd10, 7'd20, 1'b0, 1'b0, 1, 2, 0, 0, 1'b1, 1'b1, 2'b10};
        vecs[10] = '{1'b1, 6'd7,  1'b1, 7'd20, 7'd44, 1'b1, 1'b1, 1, 0, 0, 0, 1'b0, 1'b1, 2'b10};

        resetn = 1'b0; new_game = 1'b0; move_valid = 1'b0; move_pos = '0;
        clr();
        repeat (3) tick();
        check_reset_outputs("reset");
        resetn = 1'b1;
        tick();
        chk("idle_no_ready", int'(move_ready), 0);

        for (int i = 0; i < 11; i++) run_vec(i);

        // Checker never answers: watchdog must raise fault after ~512 cycles
        do_new_game();
        clr();
        hold_chk = 1'b1; exp_mover = 1'b0; exp_pos = 6'd9;
        move_valid = 1'b1; move_pos = 6'd9;
        tick();
        move_valid = 1'b0;
        cycles = 0;
        while (!fault && cycles < 700) begin
            tick();
            cycles++;
        end
        chk("timeout_fault", int'(fault), 1);
        chk("timeout_window", int'(cycles >= 505 && cycles <= 520), 1);
        chk("timeout_move_ready", int'(move_ready), 0);
        repeat (3) tick();
        chk("fault_hold", int'(fault), 1);
        hold_chk = 1'b0;
        do_new_game();

        // Reset asserted while the score counter is busy
        clr();
        hold_score = 1'b1; rsp_move_legal = 1'b1; exp_mover = 1'b0; exp_pos = 6'd19;
        move_valid = 1'b1; move_pos = 6'd19;
        tick();
        move_valid = 1'b0;
        cycles = 0;
        while (n_sstart == 0 && cycles < 50) begin
            tick();
            cycles++;
        end
        chk("count_wait_reached", n_sstart, 1);
        repeat (3) tick();
        resetn = 1'b0;
        tick();
        check_reset_outputs("mid_reset");
        resetn = 1'b1; hold_score = 1'b0;
        repeat (2) tick();
        chk("post_reset_idle", int'(move_ready), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/reversi_turn_ctrl.md
Name: reversi_turn_ctrl

Overview:
- Game-flow controller for the 8x8 reversi datapath.
- Accepts player moves over a valid/ready handshake and asks the move checker whether each move is legal.
- For a legal move it pulses the board commit, then triggers and waits on the score counter.
- It then works out whose turn is next (normal switch, forced pass, or game over) and publishes the winner.

Parameters:
- TIMEOUT, 512, max cycles to wait for chk_done or score_done before entering FAULT.
- TO_W, 10, width of the timeout counter; must satisfy 2^TO_W > TIMEOUT.

Ports:
- clk  in  1  clock.
- resetn  in  1  reset, synchronous, active-low.
- new_game  in  1  single-cycle request to start or restart a game.
- move_valid  in  1  player move offered.
- move_pos  in  6  move cell index, row*8+col.
- move_ready  out  1  controller can accept a move.
- chk_start  out  1  single-cycle pulse that starts the move checker.
- chk_mode  out  1  0 = test chk_pos; 1 = test whether chk_player has any legal move.
- chk_player  out  1  player being checked; 0 = black, 1 = white.
- chk_pos  out  6  cell under test.
- chk_done  in  1  checker finished (single-cycle pulse).
- chk_legal  in  1  checker result, valid when chk_done is high.
- commit_en  out  1  single-cycle pulse: board applies the move and its flips.
- score_init  out  1  single-cycle pulse: score counter loads 2/2.
- score_start  out  1  single-cycle pulse: start a board recount.
- score_done  in  1  recount complete (single-cycle pulse).
- score_black  in  7  black disc count, 0..64.
- score_white  in  7  white disc count, 0..64.
- cur_player  out  1  player to move.
- pass_evt  out  1  single-cycle pulse: the other player had no move and was skipped.
- illegal_move  out  1  single-cycle pulse: the offered move was rejected.
- game_over  out  1  level, game finished.
- winner  out  2  00 none, 01 black, 10 white, 11 draw.
- fault  out  1  level, checker or score counter timed out.

Behaviour:
- Reset (resetn=0 at a clk edge):
  - state=IDLE; cur_player=0, game_over=0, winner=00, fault=0.
  - All pulse outputs are 0; chk_mode=0, chk_pos=0, chk_player=0, move_ready=0.
- Priority: resetn, then new_game, then normal transitions. new_game in any state goes to INIT next cycle and aborts any in-flight check or count; done pulses arriving later are ignored.
- Cell encoding on the board: 3'b000 empty, 3'b110 white, 3'b111 black. The controller never reads the board directly.
- States and transitions:
  - IDLE: wait for new_game.
  - INIT: pulse score_init; cur_player=0 (black moves first); game_over=0, winner=00, fault=0; go to WAIT_MOVE.
  - WAIT_MOVE: move_ready=1. A transfer occurs when move_valid & move_ready; latch move_pos into chk_pos, then go to CHECK_ISSUE.
  - CHECK_ISSUE: pulse chk_start with chk_mode=0 and chk_player=cur_player; go to CHECK_WAIT.
  - CHECK_WAIT, on chk_done:
    - legal: go to COMMIT.
    - illegal: pulse illegal_move in the next cycle and return to WAIT_MOVE. cur_player is unchanged.
  - COMMIT: pulse commit_en; go to COUNT_ISSUE.
  - COUNT_ISSUE: pulse score_start; go to COUNT_WAIT.
  - COUNT_WAIT, on score_done, sample the scores that same cycle:
    - score_black+score_white==64, or either score==0: go to END.
    - otherwise: go to PROBE_OPP.
  - PROBE_OPP: pulse chk_start with chk_mode=1 and chk_player=~cur_player; wait for chk_done.
    - legal: flip cur_player; go to WAIT_MOVE.
    - not legal: go to PROBE_SELF.
  - PROBE_SELF: pulse chk_start with chk_mode=1 and chk_player=cur_player; wait for chk_done.
    - legal: pulse pass_evt, keep cur_player, go to WAIT_MOVE.
    - not legal: go to END.
  - END: set game_over=1 and winner by comparing the latched scores (equal → 11); hold until new_game.
  - FAULT: set fault=1; hold until new_game or reset.
- Timeout:
  - The counter clears on every chk_start and score_start pulse.
  - It increments each cycle in CHECK_WAIT, COUNT_WAIT and both PROBE wait phases.
  - Reaching TIMEOUT goes to FAULT.
- Score arithmetic: the sum is computed at 8 bits (no overflow).
- Every pulse output is high for exactly one cycle per entry into its state; no pulse is asserted in IDLE, END or FAULT.
- move_ready is registered and is low in every state except WAIT_MOVE. move_valid is ignored elsewhere, including on the cycle of leaving WAIT_MOVE.
- A chk_done or score_done arriving outside the matching wait state is ignored.

Decomposition:
- Shared package reversi_pkg holds:
  - cell codes CELL_EMPTY/CELL_WHITE/CELL_BLACK;
  - PLAYER_BLACK=0 / PLAYER_WHITE=1;
  - WINNER_* codes;
  - BOARD_CELLS=64, BOARD_W=192;
  - the controller state enum.
- One natural sub-module: reversi_timeout_ctr (load/enable/expired), reusable by other controllers.
- The FSM stays flat in reversi_turn_ctrl.

Test Plan:
- Reset, then new_game:
  - one cycle of score_init, then move_ready=1 and cur_player=0.
  - winner=00, game_over=0.
- Legal move at pos 19 from black:
  - chk_start, then chk_done with legal=1 gives one commit_en, then one score_start.
  - After score_done (black 4, white 1), PROBE_OPP legal=1 gives cur_player=1 and move_ready=1.
- Illegal move at pos 0:
  - illegal_move pulses once; no commit_en or score_start.
  - cur_player unchanged; move_ready back high.
- Forced pass:
  - PROBE_OPP legal=0 and PROBE_SELF legal=1 give pass_evt for one cycle.
  - cur_player unchanged.
- End of game:
  - Scores black 40, white 24 (sum 64) on score_done: game_over=1, winner=01, no probe issued.
  - Repeat with 32/32: winner=11.
  - Both probes illegal with scores 30/20: winner=01.
- Timeout and abort:
  - Withhold chk_done for 512 cycles: fault=1.
  - new_game then clears fault and pulses score_init.
  - resetn=0 during COUNT_WAIT gives IDLE with all outputs at reset values on the next edge.
